// File: rtl/button_event_sequencer.sv
// Reset-button PIO controller: programs the irq mask, then turns each PIO interrupt
// into one debounced press event (read/clear edge_capture, pulse, hold-off, flush).
module button_event_sequencer #(
    parameter int unsigned HOLDOFF_CYCLES = 500000,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned CNT_OUT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 irq,
    output logic [1:0]           pio_address,
    output logic                 pio_chipselect,
    output logic                 pio_write_n,
    output logic [31:0]          pio_writedata,
    input  logic [31:0]          pio_readdata,
    output logic                 press_pulse,
    output logic [CNT_OUT_W-1:0] press_count,
    output logic                 busy
);

    localparam logic [1:0]       ADDR_MASK = 2'd2;
    localparam logic [1:0]       ADDR_EDGE = 2'd3;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [3:0] {
        INIT_MASK,
        INIT_CLR,
        IDLE,
        READ,
        CHECK,
        CLEAR,
        EVENT,
        HOLDOFF,
        FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_OUT_W-1:0]   count_q, count_d;
    logic [1:0]             addr_q, addr_d;
    logic                   cs_q, cs_d;
    logic                   wn_q, wn_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;
    logic                   unused_rd;

    assign unused_rd = ^pio_readdata[31:1];

    // Next state; INIT_MASK holds until its write has actually been driven on the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        unique case (state_q)
            INIT_MASK: if (cs_q) state_d = INIT_CLR;
            INIT_CLR:  state_d = IDLE;
            IDLE:      if (enable && irq) state_d = READ;
            READ:      state_d = CHECK;
            CHECK:     state_d = pio_readdata[0] ? CLEAR : IDLE;
            CLEAR: begin
                state_d = EVENT;
                count_d = count_q + CNT_OUT_W'(1);
            end
            EVENT: begin
                state_d = HOLDOFF;
                cnt_d   = HOLD_LOAD;
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = FLUSH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FLUSH:     state_d = IDLE;
            default:   state_d = INIT_MASK;
        endcase
    end

    // Outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = ADDR_EDGE;
        wdata_d = 32'd0;
        pulse_d = 1'b0;
        busy_d  = (state_d != IDLE);
        unique case (state_d)
            INIT_MASK: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_MASK;
                wdata_d = 32'd1;
            end
            INIT_CLR, CLEAR, FLUSH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = 32'd1;
            end
            EVENT:   pulse_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT_MASK;
            cnt_q   <= '0;
            count_q <= '0;
            addr_q  <= 2'd0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= 32'd0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wdata_q;
    assign press_pulse    = pulse_q;
    assign press_count    = count_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_button_event_sequencer.sv
// Bench for button_event_sequencer: behavioural PIO slave, expected bus writes and
// pulses queued by the stimulus and consumed by a monitor on every DUT event.
module tb_button_event_sequencer;

    localparam int unsigned H  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned OW = 4;

    typedef struct {
        int          cyc;
        bit          pulse;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [OW-1:0] count;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          irq;
    logic [1:0]    pio_address;
    logic          pio_chipselect;
    logic          pio_write_n;
    logic [31:0]   pio_writedata;
    logic [31:0]   pio_readdata = 32'd0;
    logic          press_pulse;
    logic [OW-1:0] press_count;
    logic          busy;

    logic in_port   = 1'b1;
    logic in_prev   = 1'b1;
    logic edge_cap  = 1'b0;
    logic irq_mask  = 1'b0;
    logic force_irq = 1'b0;

    ev_t           exp_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [OW-1:0] exp_count;

    button_event_sequencer #(
        .HOLDOFF_CYCLES(H),
        .CNT_W(CW),
        .CNT_OUT_W(OW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .irq(irq),
        .pio_address(pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata),
        .press_pulse(press_pulse),
        .press_count(press_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: falling-edge capture, clear-on-write has priority, registered readdata.
    always @(posedge clk) begin
        in_prev <= in_port;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            irq_mask <= pio_writedata[0];
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_cap <= 1'b0;
        else if (in_prev && !in_port)
            edge_cap <= 1'b1;
        case (pio_address)
            2'd0:    pio_readdata <= {31'd0, in_port};
            2'd2:    pio_readdata <= {31'd0, irq_mask};
            2'd3:    pio_readdata <= {31'd0, edge_cap};
            default: pio_readdata <= 32'd0;
        endcase
    end

    assign irq = (edge_cap & irq_mask) | force_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input bit p, input logic [1:0] a,
                           input logic [31:0] d, input logic [OW-1:0] n);
        ev_t e;
        e.cyc = c; e.pulse = p; e.addr = a; e.data = d; e.count = n;
        exp_q.push_back(e);
    endtask

    // irq seen in IDLE at cycle t: CLEAR t+3, pulse t+4, FLUSH t+5+H.
    task automatic push_press(input int t, input bit flush);
        exp_count = exp_count + OW'(1);
        push_ev(t + 3, 1'b0, 2'd3, 32'd1, '0);
        push_ev(t + 4, 1'b1, 2'd0, 32'd0, exp_count);
        if (flush) push_ev(t + 5 + int'(H), 1'b0, 2'd3, 32'd1, '0);
    endtask

    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset_n && ((pio_chipselect && !pio_write_n) || press_pulse)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected cyc=%0d actual cs=%0b pulse=%0b addr=%0d expected no event",
                             cyc, pio_chipselect, press_pulse, pio_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cycle", 32'(cyc), 32'(e.cyc));
                    chk("sb_pulse", 32'(press_pulse), 32'(e.pulse));
                    if (e.pulse) begin
                        chk("sb_count", 32'(press_count), 32'(e.count));
                        chk("sb_pulse_no_write", 32'(pio_chipselect), 32'd0);
                    end else begin
                        chk("sb_addr", 32'(pio_address), 32'(e.addr));
                        chk("sb_wdata", pio_writedata, e.data);
                    end
                end
            end
        end
    endtask

    task automatic reset_release();
        int c;
        c = cyc;
        reset_n = 1'b1;
        push_ev(c + 1, 1'b0, 2'd2, 32'd1, '0);
        push_ev(c + 2, 1'b0, 2'd3, 32'd1, '0);
        repeat (3) @(negedge clk);
        chk("init_idle_busy", 32'(busy), 32'd0);
        chk("init_irq_mask", 32'(irq_mask), 32'd1);
    endtask

    initial begin
        int c;
        reset_n   = 1'b0;
        enable    = 1'b1;
        exp_count = '0;
        fork
            monitor_loop();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cs", 32'(pio_chipselect), 32'd0);
        chk("rst_write_n", 32'(pio_write_n), 32'd1);
        chk("rst_addr", 32'(pio_address), 32'd0);
        chk("rst_wdata", pio_writedata, 32'd0);
        chk("rst_pulse", 32'(press_pulse), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        reset_release();

        // Clean press
        @(negedge clk);
        c = cyc;
        in_port = 1'b0;
        push_press(c + 1, 1'b1);
        repeat (int'(H) + 6) @(negedge clk);
        chk("clean_flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("clean_idle_busy", 32'(busy), 32'd0);
        chk("clean_count", 32'(press_count), 32'(exp_count));
        in_port = 1'b1;

        // Bouncy press: toggles for six cycles, ends low
        @(negedge clk);
        c = cyc;
        in_port = 1'b0;
        push_press(c + 1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_port = (k % 2 == 1);
        end
        repeat (10) @(negedge clk);
        chk("bounce_edge_cap", 32'(edge_cap), 32'd0);
        chk("bounce_irq", 32'(irq), 32'd0);
        chk("bounce_count", 32'(press_count), 32'(exp_count));
        chk("bounce_busy", 32'(busy), 32'd0);
        in_port = 1'b1;

        // Spurious irq: edge_capture reads 0 at CHECK
        @(negedge clk);
        force_irq = 1'b1;
        @(negedge clk);
        force_irq = 1'b0;
        chk("spur_read_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_count", 32'(press_count), 32'(exp_count));

        // Press while disabled, serviced once enable returns
        @(negedge clk);
        enable  = 1'b0;
        in_port = 1'b0;
        repeat (5) @(negedge clk);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_irq", 32'(irq), 32'd1);
        c = cyc;
        enable = 1'b1;
        push_press(c, 1'b1);
        repeat (int'(H) + 7) @(negedge clk);
        chk("en_count", 32'(press_count), 32'(exp_count));
        chk("en_busy", 32'(busy), 32'd0);
        in_port = 1'b1;

        // Reset asserted during HOLDOFF
        @(negedge clk);
        c = cyc;
        in_port = 1'b0;
        push_press(c + 1, 1'b0);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_count", 32'(press_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_cs", 32'(pio_chipselect), 32'd0);
        chk("midrst_write_n", 32'(pio_write_n), 32'd1);
        chk("midrst_pulse", 32'(press_pulse), 32'd0);
        chk("midrst_addr", 32'(pio_address), 32'd0);
        exp_count = '0;
        @(negedge clk);
        reset_release();
        in_port = 1'b1;

        // Counter wrap over 2^OW presses
        for (int i = 0; i < (1 << OW); i++) begin
            @(negedge clk);
            c = cyc;
            in_port = 1'b0;
            push_press(c + 1, 1'b1);
            repeat (int'(H) + 7) @(negedge clk);
            in_port = 1'b1;
        end
        chk("wrap_model", 32'(press_count), 32'(exp_count));
        chk("wrap_zero", 32'(press_count), 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
